// File: rtl/switch_debounce_pkg.sv
// Shared constants for the switch conditioning path
// between the inverted switch pins and gp_i.
package switch_debounce_pkg;

  localparam int SysClkFreq = 30_000_000;

  localparam int GpiNavWidth  = 5;
  localparam int GpiUserWidth = 8;
  localparam int GpiSelWidth  = 3;

  localparam int SwDebounceWidth =
    GpiNavWidth + GpiUserWidth + GpiSelWidth;

  localparam int SwDebounceTickCycles = SysClkFreq / 1000;
  localparam int SwDebounceSyncStages  = 2;
  localparam int SwDebounceStableTicks = 5;

endpackage

// File: rtl/switch_debounce_if.sv
// Switch input/output bundle: raw levels and bypass in,
// debounced levels and edge events out.
interface switch_debounce_if
  import switch_debounce_pkg::*;
#(
  parameter int Width = SwDebounceWidth
);

  logic [Width-1:0] sw_i;
  logic             bypass_i;
  logic [Width-1:0] sw_o;
  logic [Width-1:0] rise_o;
  logic [Width-1:0] fall_o;
  logic             changed_o;

  modport master (
    output sw_i, bypass_i,
    input  sw_o, rise_o, fall_o, changed_o
  );

  modport slave (
    input  sw_i, bypass_i,
    output sw_o, rise_o, fall_o, changed_o
  );

endinterface

// File: rtl/switch_debounce_bit.sv
// Single-bit stability counter, debounced level
// and registered edge detection.
module switch_debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int   StableTicks = SwDebounceStableTicks,
  parameter logic ResetValue  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic s_i,
  input  logic tick_i,
  input  logic bypass_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CntW = $clog2(StableTicks + 1);
  localparam logic [CntW-1:0] CntLast =
    CntW'(StableTicks - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sw_q, sw_d;
  logic            prev_q;
  logic            rise_q, fall_q;

  always_comb begin
    cnt_d = cnt_q;
    sw_d  = sw_q;
    if (bypass_i) begin
      cnt_d = '0;
      sw_d  = s_i;
    end else if (tick_i) begin
      if (s_i == sw_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        cnt_d = '0;
        sw_d  = s_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // prev_q trails sw_q so edges appear the cycle after sw_o moves
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sw_q   <= ResetValue;
      prev_q <= ResetValue;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sw_q   <= sw_d;
      prev_q <= sw_q;
      rise_q <= sw_q & ~prev_q;
      fall_q <= ~sw_q & prev_q;
    end
  end

  assign sw_o   = sw_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/switch_debounce.sv
// Synchroniser, shared sample-tick prescaler and
// per-bit debounce for the board switch inputs.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int Width       = SwDebounceWidth,
  parameter int SyncStages  = SwDebounceSyncStages,
  parameter int TickCycles  = SwDebounceTickCycles,
  parameter int StableTicks = SwDebounceStableTicks,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input logic          clk_i,
  input logic          rst_ni,
  switch_debounce_if.slave bus
);

  localparam int PreW = $clog2(TickCycles);
  localparam logic [PreW-1:0] PreLast =
    PreW'(TickCycles - 1);

  logic [PreW-1:0]  pre_q, pre_d;
  logic             tick;
  logic [Width-1:0] sync_q [SyncStages];
  logic [Width-1:0] sw, rise, fall;

  assign tick  = (pre_q == PreLast);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SyncStages; i++) begin
        sync_q[i] <= ResetValue;
      end
    end else begin
      sync_q[0] <= bus.sw_i;
      for (int i = 1; i < SyncStages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  for (genvar g = 0; g < Width; g++) begin : g_bit
    switch_debounce_bit #(
      .StableTicks (StableTicks),
      .ResetValue  (ResetValue[g])
    ) u_bit (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .s_i      (sync_q[SyncStages-1][g]),
      .tick_i   (tick),
      .bypass_i (bus.bypass_i),
      .sw_o     (sw[g]),
      .rise_o   (rise[g]),
      .fall_o   (fall[g])
    );
  end

  assign bus.sw_o      = sw;
  assign bus.rise_o    = rise;
  assign bus.fall_o    = fall;
  assign bus.changed_o = |(rise | fall);

endmodule

// File: tb/tb_switch_debounce.sv
// Directed and random checks of switch_debounce against
// a window-over-tick-samples reference model.
module tb_switch_debounce;

  localparam int W  = 4;
  localparam int TC = 4;
  localparam int ST = 3;
  localparam int SS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  switch_debounce_if #(.Width(W)) bus ();

  switch_debounce #(
    .Width       (W),
    .SyncStages  (SS),
    .TickCycles  (TC),
    .StableTicks (ST),
    .ResetValue  ('0)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int total  = 0;
  int bad    = 0;
  int edges  = 0;
  int npulse = 0;
  int lat;
  int snap;

  logic [W-1:0] swq [$];
  logic [W-1:0] tsamp [$];
  int           seg [W];
  logic [W-1:0] out, out1, out2;

  task automatic chk(string tag, logic [W-1:0] got,
                     logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_rng(string tag, int v, int lo, int hi);
    total++;
    assert (v >= lo && v <= hi) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic mreset();
    swq.delete();
    repeat (SS) swq.push_back('0);
    tsamp.delete();
    for (int i = 0; i < W; i++) seg[i] = 0;
    out   = '0;
    out1  = '0;
    out2  = '0;
    edges = 0;
  endtask

  task automatic check_all();
    chk("sw_o", bus.sw_o, out);
    chk("rise_o", bus.rise_o, out1 & ~out2);
    chk("fall_o", bus.fall_o, ~out1 & out2);
    chk("changed_o", W'(bus.changed_o), W'(|(out1 ^ out2)));
  endtask

  // Model: a bit flips once its last ST tick samples,
  // all taken since its previous flip/bypass/reset, all
  // disagree with the current output.
  task automatic cyc();
    logic [W-1:0] s;
    logic [W-1:0] nout;
    bit           all;
    int           n;
    @(posedge clk);
    #1;
    if (rst_n) begin
      edges++;
      swq.push_back(bus.sw_i);
      s    = swq.pop_front();
      nout = out;
      if (bus.bypass_i) begin
        nout = s;
        for (int i = 0; i < W; i++) seg[i] = tsamp.size();
      end else if (edges % TC == 0) begin
        tsamp.push_back(s);
        for (int i = 0; i < W; i++) begin
          n = tsamp.size() - seg[i];
          if (n >= ST) begin
            all = 1'b1;
            for (int k = 1; k <= ST; k++)
              if (tsamp[tsamp.size()-k][i] == out[i])
                all = 1'b0;
            if (all) begin
              nout[i] = s[i];
              seg[i]  = tsamp.size();
            end
          end
        end
      end
      out2 = out1;
      out1 = out;
      out  = nout;
    end
    if (|(bus.rise_o | bus.fall_o)) npulse++;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    mreset();
    check_all();
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic wait_rise(int b, output int l);
    l = 999;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (bus.sw_o[b]) begin
        l = n;
        break;
      end
    end
  endtask

  initial begin
    bus.sw_i     = '0;
    bus.bypass_i = 1'b0;
    #2;
    do_reset();

    // 1: quiet inputs
    repeat (100) cyc();
    chk_rng("t1_pulses", npulse, 0, 0);

    // 2: clean step on bit 0
    bus.sw_i[0] = 1'b1;
    wait_rise(0, lat);
    chk_rng("t2_latency", lat, 11, 15);
    cyc();
    chk("t2_rise", bus.rise_o, 4'b0001);
    chk("t2_changed", W'(bus.changed_o), 4'b0001);
    repeat (5) cyc();

    // 3: short pulse on bit 1 is filtered
    snap = npulse;
    bus.sw_i[1] = 1'b1;
    repeat (6) cyc();
    bus.sw_i[1] = 1'b0;
    repeat (30) cyc();
    chk("t3_sw1", W'(bus.sw_o[1]), '0);
    chk_rng("t3_pulses", npulse - snap, 0, 0);

    // 4: 1,0,1 on successive ticks restarts the count
    bus.sw_i[2] = 1'b1;
    repeat (TC) cyc();
    bus.sw_i[2] = 1'b0;
    repeat (TC) cyc();
    bus.sw_i[2] = 1'b1;
    wait_rise(2, lat);
    chk_rng("t4_latency", lat, 11, 15);
    repeat (5) cyc();

    // 5: bypass passes the synchronised value
    bus.bypass_i = 1'b1;
    repeat (4) cyc();
    bus.sw_i = 4'b1010;
    cyc();
    chk("t5_c1", bus.sw_o, 4'b0101);
    cyc();
    chk("t5_c2", bus.sw_o, 4'b0101);
    cyc();
    chk("t5_c3", bus.sw_o, 4'b1010);
    cyc();
    chk("t5_rise", bus.rise_o, 4'b1010);
    chk("t5_fall", bus.fall_o, 4'b0101);
    repeat (3) cyc();
    snap = npulse;
    bus.bypass_i = 1'b0;
    repeat (20) cyc();
    chk_rng("t5_no_pulse", npulse - snap, 0, 0);
    chk("t5_hold", bus.sw_o, 4'b1010);

    // 6: reset in the middle of an accepted count
    bus.sw_i = '0;
    do_reset();
    repeat (10) cyc();
    bus.sw_i[3] = 1'b1;
    repeat (10) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_sw", bus.sw_o, '0);
    chk("t6_async_rise", bus.rise_o, '0);
    mreset();
    repeat (2) cyc();
    rst_n = 1'b1;
    wait_rise(3, lat);
    chk_rng("t6_latency", lat, 11, 15);

    // 7: random traffic with glitches and bypass toggles
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 24) == 0)
        bus.sw_i = W'($urandom);
      else if ($urandom_range(0, 39) == 0)
        bus.sw_i[$urandom_range(0, W-1)] ^= 1'b1;
      if ($urandom_range(0, 299) == 0)
        bus.bypass_i = ~bus.bypass_i;
      if (n == 2000) begin
        bus.bypass_i = 1'b0;
        do_reset();
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Conditions the board's raw mechanical inputs (joystick, user DIP switches, software-select switches) before they reach the system GPIO input word.
- Per-bit processing: double-flop synchronisation into clk_i, a shared sample-tick prescaler, and a per-bit stability counter that accepts a new level only after it has held for StableTicks consecutive ticks.
- Also emits single-cycle rise/fall event pulses per bit.
- Sits between the inverted top-level switch pins and the system's gp_i input.

Parameters:
- Width, 16, number of independent input bits (5 nav + 8 user + 3 select).
- SyncStages, 2, synchroniser flop depth; legal range ≥2.
- TickCycles, 30000, clk_i cycles per sample tick (1 ms at 30 MHz); legal range ≥2.
- StableTicks, 5, consecutive differing ticks required to accept a new level; legal range ≥1.
- ResetValue, '0, Width-bit value for synchroniser flops and sw_o at reset.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- sw_i  input  Width  raw asynchronous switch levels, active-high (1 = on).
- bypass_i  input  1  quasi-static; 1 = skip debounce and pass synchronised value straight through.
- sw_o  output  Width  debounced level.
- rise_o  output  Width  one-cycle pulse when sw_o[i] goes 0->1.
- fall_o  output  Width  one-cycle pulse when sw_o[i] goes 1->0.
- changed_o  output  1  OR of rise_o|fall_o; registered with them.

Behaviour:
- Reset: sync flops = ResetValue, sw_o = ResetValue, rise_o = fall_o = 0, changed_o = 0, prescaler = 0, all bit counters = 0.
  - No edge pulses are generated by reset release itself.
- Synchroniser: sw_i passes through SyncStages flops; call the result s[i]. No logic sits between stages.
- Prescaler:
  - Counts 0..TickCycles-1 and wraps.
  - tick is high for the single cycle where count == TickCycles-1.
  - Free-running; unaffected by bypass_i.
- Per-bit counter cnt[i], width $clog2(StableTicks+1). It updates only on tick:
  - If s[i] == sw_o[i]: cnt <= 0.
  - Else if cnt == StableTicks-1: sw_o[i] <= s[i] and cnt <= 0 in the same cycle.
  - Else: cnt <= cnt+1.
- A single matching sample restarts the count. Glitches shorter than StableTicks ticks are never propagated.
- Latency from a stable sw_i step to the sw_o change:
  - Minimum: SyncStages + (StableTicks-1)*TickCycles + 1 cycles.
  - Maximum: SyncStages + StableTicks*TickCycles + 1 cycles.
  - The exact value depends on prescaler phase.
- Edge outputs:
  - rise_o/fall_o/changed_o are registered and assert on the cycle after sw_o changes, for exactly one cycle.
  - Different bits may pulse simultaneously.
- Bypass:
  - While bypass_i = 1: sw_o <= s every cycle, all cnt held at 0, edges still generated.
  - On bypass_i 1->0: sw_o keeps its current value and debouncing resumes from cnt = 0. No spurious edge is produced.
- Reset asserted mid-count: all state returns to reset values immediately (asynchronous), and no pulse is produced.
- All bits are independent; there are no cross-bit dependencies other than the shared tick.

Decomposition:
- Add to sonata_pkg:
  - GpiNavWidth = 5, GpiUserWidth = 8, GpiSelWidth = 3.
  - SwDebounceWidth = their sum.
  - SwDebounceTickCycles derived from SysClkFreq/1000.
- One sub-module, switch_debounce_bit: holds cnt, the sw_o bit and the edge flops for a single bit. It takes s, tick and bypass as inputs.
- The top level holds the synchroniser, the prescaler and a generate loop over Width.

Test Plan (TickCycles=4, StableTicks=3, SyncStages=2, Width=4, ResetValue=0):
1. Reset, then sw_i held at 4'b0000 for 100 cycles -> sw_o = 0; rise_o, fall_o and changed_o never assert.
2. sw_i[0] steps 0->1 and holds -> sw_o[0] rises between 11 and 15 cycles after the step; rise_o[0] = 1 for exactly the following cycle; changed_o = 1 on the same cycle.
3. sw_i[1] pulses high for 6 cycles, then low -> sw_o[1] stays 0; no rise_o or fall_o pulse on bit 1.
4. sw_i[2] toggles 1,0,1 on consecutive ticks, then holds 1 -> count restarts on the 0 sample; sw_o[2] rises only after 3 further consecutive high ticks.
5. bypass_i = 1, then sw_i = 4'b1010 -> sw_o = 4'b1010 exactly SyncStages+1 = 3 cycles later; rise_o = 4'b1010 for one cycle. bypass_i then drops -> no pulse.
6. rst_ni asserted 2 ticks into an accepted change on bit 3 -> sw_o[3] = 0 immediately. After release, sw_o[3] needs a full 3-tick count to rise.
